// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
//   Shared definitions for the split-memory, non-power-of-two dual-clock FIFO.
//   Used by both the read side (fifo_rd_stream) and the write side.
//   - len_sum()   : total depth of the large + small memory pair
//   - ptr_inc()   : address/lap advance with the FIFO's wrap rule
//   - occupancy() : words present between a write and a read pointer
//   Pointers are carried at a fixed 32-bit width here; callers cast to and
//   from their own PW-bit ports.
package fifo_rd_stream_pkg;

  localparam int unsigned PTR_MAXW = 32;

  typedef logic [PTR_MAXW-1:0] addr_t;

  // Address plus lap bit; the lap bit toggles every time the address wraps.
  typedef struct packed {
    logic  lap;
    addr_t adr;
  } fptr_t;

  function automatic int unsigned len_sum(input int unsigned log_a,
                                          input int unsigned log_b);
    return (32'd1 << log_a) + (32'd1 << log_b);
  endfunction

  // The depth is not a power of two, so the wrap is an explicit compare
  // against the last address rather than a natural counter rollover.
  function automatic fptr_t ptr_inc(input fptr_t p, input int unsigned lsum);
    fptr_t r;
    if (p.adr == addr_t'(lsum - 1)) begin
      r.adr = '0;
      r.lap = ~p.lap;
    end else begin
      r.adr = p.adr + addr_t'(1);
      r.lap = p.lap;
    end
    return r;
  endfunction

  // Same lap: plain difference. Different lap: writer has wrapped once more
  // than the reader, so the gap runs through the end of the address space.
  function automatic logic [PTR_MAXW:0] occupancy(input fptr_t w,
                                                  input fptr_t r,
                                                  input int unsigned lsum);
    if (w.lap == r.lap) begin
      return {1'b0, w.adr} - {1'b0, r.adr};
    end else begin
      return {1'b0, addr_t'(lsum)} - {1'b0, r.adr} + {1'b0, w.adr};
    end
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if
//   Valid/ready stream carrying FIFO read data downstream.
//   m_valid : word present on m_data
//   m_data  : DW-bit payload
//   m_ready : consumer accepts the word this cycle
//   master modport drives valid/data, slave modport drives ready.
interface fifo_rd_stream_if #(
  parameter int unsigned DW = 32
) ();

  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_rd_obuf.sv
// fifo_rd_obuf
//   Small single-clock circular buffer that absorbs FIFO read data while the
//   stream consumer stalls.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of indices and count, wins over push/pop
//   push, din  : write one word
//   pop        : remove the head word (ignored when empty)
//   dout       : head word
//   count      : number of stored words, 0..2**LOG
module fifo_rd_obuf #(
  parameter int unsigned DW  = 32,
  parameter int unsigned LOG = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [LOG:0]  count
);

  localparam int unsigned DEPTH = 1 << LOG;

  logic [DW-1:0]  mem_q [DEPTH];
  logic [DW-1:0]  mem_d [DEPTH];
  logic [LOG-1:0] widx_q, widx_d;
  logic [LOG-1:0] ridx_q, ridx_d;
  logic [LOG:0]   count_q, count_d;
  logic           pop_ok;

  always_comb begin
    mem_d   = mem_q;
    widx_d  = widx_q;
    ridx_d  = ridx_q;
    count_d = count_q;
    pop_ok  = pop & (count_q != '0);
    if (clr) begin
      widx_d  = '0;
      ridx_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[widx_q] = din;
        widx_d        = widx_q + 1'b1;
      end
      if (pop_ok) begin
        ridx_d = ridx_q + 1'b1;
      end
      // Land and pop in the same cycle cancel out.
      if (push & ~pop_ok) begin
        count_d = count_q + 1'b1;
      end else if (~push & pop_ok) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      widx_q  <= '0;
      ridx_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      widx_q  <= widx_d;
      ridx_q  <= ridx_d;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[ridx_q];
  assign count = count_q;

  // The controller's credit accounting must never let a word land in a
  // full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clr && count_q == (LOG+1)'(DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side controller of the split-memory dual-clock FIFO. Converts the
//   FIFO's deq/dot read port into a valid/ready stream, tracking the read
//   pointer with the FIFO wrap rule and issuing reads only when data is
//   present and output-buffer space is guaranteed.
//   CLK, RST_X  : read clock, asynchronous active-low reset
//   srst        : synchronous clear (shared with the FIFO RRST)
//   wptr, wlap  : write pointer/lap, already synchronized into CLK domain
//   deq, dot    : FIFO read strobe and read data (dot valid RD_LAT later)
//   rptr, rlap  : read pointer/lap exported to the write side
//   m           : output stream (master side)
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned LEN_LOG_A = 12,
  parameter int unsigned LEN_LOG_B = 9,
  parameter int unsigned LEN_SUM   = len_sum(LEN_LOG_A, LEN_LOG_B),
  parameter int unsigned PW        = LEN_LOG_A + 1,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned OB_LOG    = 2
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic                srst,
  input  logic [PW-1:0]       wptr,
  input  logic                wlap,
  output logic                deq,
  input  logic [DW-1:0]       dot,
  output logic [PW-1:0]       rptr,
  output logic                rlap,
  fifo_rd_stream_if.master    m
);

  localparam int unsigned OB_DEPTH = 1 << OB_LOG;
  // Wide enough for ob_count + inflight, both bounded by OB_DEPTH.
  localparam int unsigned CW       = OB_LOG + 2;

  logic [PW-1:0]     rptr_q, rptr_d;
  logic              rlap_q, rlap_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  fptr_t             wp, rp, inc_p;
  logic [PTR_MAXW:0] occ;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     used;
  logic              has_cred;
  logic              issue;

  logic [OB_LOG:0]   ob_count;
  logic [DW-1:0]     ob_dout;
  logic              ob_valid;
  logic              ob_pop;
  logic              land;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
  end

  always_comb begin
    wp       = '{lap: wlap,   adr: addr_t'(wptr)};
    rp       = '{lap: rlap_q, adr: addr_t'(rptr_q)};
    occ      = occupancy(wp, rp, LEN_SUM);
    inc_p    = ptr_inc(rp, LEN_SUM);
    used     = CW'(ob_count) + inflight;
    has_cred = used < CW'(OB_DEPTH);
    issue    = ~srst & (occ != '0) & has_cred;

    rptr_d = rptr_q;
    rlap_d = rlap_q;
    vld_d  = RD_LAT'({vld_q, issue});
    if (srst) begin
      rptr_d = '0;
      rlap_d = 1'b0;
      vld_d  = '0;
    end else if (issue) begin
      rptr_d = PW'(inc_p.adr);
      rlap_d = inc_p.lap;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rptr_q <= '0;
      rlap_q <= 1'b0;
      vld_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      rlap_q <= rlap_d;
      vld_q  <= vld_d;
    end
  end

  // The reset gate is applied only to the exported strobe, not to the
  // internal issue term that feeds the pointer flops, so the async reset
  // net never enters a flop data path.
  assign deq  = issue & RST_X;
  assign rptr = rptr_q;
  assign rlap = rlap_q;

  assign land     = vld_q[RD_LAT-1];
  assign ob_valid = (ob_count != '0);
  assign ob_pop   = ob_valid & m.m_ready;

  fifo_rd_obuf #(
    .DW  (DW),
    .LOG (OB_LOG)
  ) u_obuf (
    .clk   (CLK),
    .rst_n (RST_X),
    .clr   (srst),
    .push  (land),
    .din   (dot),
    .pop   (ob_pop),
    .dout  (ob_dout),
    .count (ob_count)
  );

  assign m.m_valid = ob_valid;
  assign m.m_data  = ob_dout;

endmodule
